// File: rtl/slicem_write_ctrl.sv
// Serialises a write request into single-bit LUT-RAM writes: req_len cycles of write_en, then a one-cycle done pulse.
// Backpressure: req_ready is high only in IDLE. Requests offered while busy are ignored, never queued.
module slicem_write_ctrl #(
    parameter int S_XX_BASE = 4,
    parameter int NUM_LUTS  = 4,
    parameter int MUX_LVLS  = $clog2(NUM_LUTS),
    parameter int WORD_W    = 8,
    localparam int ADDR_W   = MUX_LVLS + 1 + S_XX_BASE,
    localparam int LEN_W    = $clog2(WORD_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WORD_W-1:0]    req_data,
    input  logic [LEN_W-1:0]     req_len,
    output logic                 write_en,
    output logic                 data_in_o,
    output logic [S_XX_BASE-1:0] lut_addr,
    output logic                 write_lut_select,
    output logic [MUX_LVLS-1:0]  higher_order_addr,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WORD_W-1:0]  shift_q;
    logic [ADDR_W-1:0]  cur_addr_q;
    logic [LEN_W-1:0]   remain_q;
    logic [LEN_W-1:0]   len_clamped;
    logic               req_hs;

    assign len_clamped = (req_len > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : req_len;
    assign req_hs      = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs) state_d = (len_clamped == '0) ? DONE : WRITE;
            WRITE:   if (remain_q == LEN_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Zero-length requests leave the datapath untouched; they only pass through DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q    <= '0;
            cur_addr_q <= '0;
            remain_q   <= '0;
        end else if (req_hs && (len_clamped != '0)) begin
            shift_q    <= req_data;
            cur_addr_q <= req_addr;
            remain_q   <= len_clamped;
        end else if (state_q == WRITE) begin
            shift_q    <= shift_q >> 1;
            cur_addr_q <= cur_addr_q + ADDR_W'(1);
            remain_q   <= remain_q - LEN_W'(1);
        end
    end

    assign req_ready         = (state_q == IDLE);
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign write_en          = (state_q == WRITE);
    assign data_in_o         = write_en & shift_q[0];
    assign lut_addr          = cur_addr_q[S_XX_BASE-1:0];
    assign write_lut_select  = cur_addr_q[S_XX_BASE];
    assign higher_order_addr = cur_addr_q[ADDR_W-1:S_XX_BASE+1];

endmodule

// File: tb/tb_slicem_write_ctrl.sv
// Directed bench for slicem_write_ctrl at default parameters (7-bit address, 8-bit word).
module tb_slicem_write_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic [3:0] req_len;
    logic       write_en;
    logic       data_in_o;
    logic [3:0] lut_addr;
    logic       write_lut_select;
    logic [1:0] higher_order_addr;
    logic       busy;
    logic       done;

    slicem_write_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .req_len           (req_len),
        .write_en          (write_en),
        .data_in_o         (data_in_o),
        .lut_addr          (lut_addr),
        .write_lut_select  (write_lut_select),
        .higher_order_addr (higher_order_addr),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Per-request capture, indexed by write order.
    logic [7:0] wr_bits;
    logic [6:0] wr_addr [16];
    logic       wr_sel  [16];
    logic [1:0] wr_hoa  [16];
    int         wr_k    [16];
    int         n_wr;
    int         done_k;
    int         busy_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic record(input int k);
        if (write_en) begin
            if (n_wr < 16) begin
                if (n_wr < 8) wr_bits[n_wr] = data_in_o;
                wr_addr[n_wr] = {higher_order_addr, write_lut_select, lut_addr};
                wr_sel[n_wr]  = write_lut_select;
                wr_hoa[n_wr]  = higher_order_addr;
                wr_k[n_wr]    = k;
            end
            n_wr++;
        end
        if (busy !== 1'b1 || req_ready !== 1'b0) busy_bad++;
        if (done && write_en) busy_bad++;
        if (done) done_k = k;
    endtask

    // Handshake at edge E, then observe cycles E+1.. until done; finally check cycle done_k+1.
    task automatic send(input logic [6:0] a, input logic [7:0] d, input logic [3:0] l, input string tag);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_data = d; req_len = l;
        @(posedge clk);
        n_wr = 0; done_k = 0; busy_bad = 0; wr_bits = '0;
        for (int k = 1; k <= 20 && done_k == 0; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            record(k);
        end
        if (done_k == 0) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_busy_rdy"}, busy_bad, 0);
        @(negedge clk);
        chk({tag, "_ready_after"}, {done, write_en, req_ready}, 3'b001);
    endtask

    logic [7:0] exp_byte;
    int         post_bad;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {write_en, data_in_o, busy, done, higher_order_addr, write_lut_select, lut_addr},
            11'h000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);

        // 0xA5 from address 0: bits LSB first, lut_addr 0..7 in half 0 of LUT 0.
        send(7'h00, 8'hA5, 4'd8, "a5");
        chk("a5_nwr", n_wr, 8);
        chk("a5_first_k", wr_k[0], 1);
        chk("a5_done_k", done_k, 9);
        exp_byte = 8'hA5;
        chk("a5_bits", wr_bits, exp_byte);
        for (int i = 0; i < 8; i++) chk("a5_addr", wr_addr[i], i);

        // 0x1E crosses into LUT 1: address bit 4 is set for 0x1E/0x1F and clear for 0x20/0x21.
        send(7'h1E, 8'h0F, 4'd4, "x1e");
        chk("x1e_nwr", n_wr, 4);
        chk("x1e_done_k", done_k, 5);
        chk("x1e_bits", wr_bits[3:0], 4'hF);
        chk("x1e_addr", {wr_addr[0], wr_addr[1], wr_addr[2], wr_addr[3]}, {7'h1E, 7'h1F, 7'h20, 7'h21});
        chk("x1e_sel", {wr_sel[0], wr_sel[1], wr_sel[2], wr_sel[3]}, 4'b1100);
        chk("x1e_hoa", {wr_hoa[0], wr_hoa[1], wr_hoa[2], wr_hoa[3]}, 8'b00_00_01_01);

        // Wrap from the top address back to zero.
        send(7'h7F, 8'h02, 4'd2, "wrap");
        chk("wrap_nwr", n_wr, 2);
        chk("wrap_addr", {wr_addr[0], wr_addr[1]}, {7'h7F, 7'h00});
        chk("wrap_hoa", {wr_hoa[0], wr_hoa[1]}, 4'b11_00);
        chk("wrap_bits", wr_bits[1:0], 2'b10);

        // Zero length: straight to DONE.
        send(7'h33, 8'hFF, 4'd0, "len0");
        chk("len0_nwr", n_wr, 0);
        chk("len0_done_k", done_k, 1);

        // Oversized length clamps to eight bits.
        send(7'h40, 8'h3C, 4'd12, "clamp");
        chk("clamp_nwr", n_wr, 8);
        chk("clamp_done_k", done_k, 9);
        chk("clamp_bits", wr_bits, 8'h3C);
        chk("clamp_last_addr", wr_addr[7], 7'h47);

        // Valid held with churning inputs, then reset in the third write cycle.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 7'h10; req_data = 8'hC3; req_len = 4'd6;
        @(posedge clk);
        n_wr = 0; done_k = 0; busy_bad = 0; wr_bits = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            record(k);
            req_addr = 7'(k * 11); req_data = 8'(k * 37); req_len = 4'd8;
            if (k == 3) rst_n = 1'b0;
        end
        chk("abort_nwr", n_wr, 3);
        chk("abort_bits", wr_bits[2:0], 3'b011);
        chk("abort_addr", {wr_addr[0], wr_addr[1], wr_addr[2]}, {7'h10, 7'h11, 7'h12});
        @(negedge clk);
        chk("abort_after_rst", {write_en, done, busy}, 3'b000);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", req_ready, 1'b1);
        post_bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (write_en || done || busy) post_bad++;
            @(negedge clk);
        end
        chk("abort_quiet", post_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
